// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers and write-side FSM state encoding.
package fifo_pkg;

   localparam int unsigned PTR_MAX = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } wr_state_e;

   // Modulo-depth pointer increment.
   function automatic logic [PTR_MAX-1:0] inc(input logic [PTR_MAX-1:0] x,
                                              input int unsigned       depth);
      return (x == PTR_MAX'(depth - 1)) ? '0 : x + PTR_MAX'(1);
   endfunction

   function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs convert identically at any narrower width.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
      logic [PTR_MAX-1:0] b;
      b[PTR_MAX-1] = g[PTR_MAX-1];
      for (int i = PTR_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_gray_conv.sv
// Binary-to-Gray and Gray-to-binary pointer conversion, shared by both FIFO sides.
module fifo_gray_conv
   import fifo_pkg::*;
#(
   parameter int unsigned PTR_SZ = 2
) (
   input  logic [PTR_SZ-1:0] bin_i,
   input  logic [PTR_SZ-1:0] gray_i,
   output logic [PTR_SZ-1:0] gray_c_o,
   output logic [PTR_SZ-1:0] bin_c_o
);

   always_comb begin
      gray_c_o = PTR_SZ'(bin2gray(PTR_MAX'(bin_i)));
      bin_c_o  = PTR_SZ'(gray2bin(PTR_MAX'(gray_i)));
   end

endmodule

// File: rtl/fifo_write_logic.sv
// FIFO write side: one write per winc episode, wrapping write pointer and full flag.
// Optional sticky overflow output enabled by defining FIFO_WRITE_OVERFLOW_EN.
module fifo_write_logic
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned PTR_SZ = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              winc,
   input  logic [PTR_SZ-1:0] rq2_raddr,
   output logic              wfull,
   output logic              write_en,
   output logic [PTR_SZ-1:0] waddr,
   output logic [PTR_SZ-1:0] waddr_gray
`ifdef FIFO_WRITE_OVERFLOW_EN
   ,
   output logic              woverflow
`endif
);

   wr_state_e         state_q, state_d;
   logic [PTR_SZ-1:0] waddr_q, waddr_d;
   logic [PTR_SZ-1:0] raddr;
   logic              wfull_q, write_en_q;
   logic              full_next, full_at_zero;

   fifo_gray_conv #(.PTR_SZ(PTR_SZ)) u_conv (
      .bin_i    (waddr_q),
      .gray_i   (rq2_raddr),
      .gray_c_o (waddr_gray),
      .bin_c_o  (raddr)
   );

   // Next state and pointer; the pointer only advances on leaving WRITE.
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      unique case (state_q)
         IDLE:    if (winc && !wfull_q) state_d = WRITE;
         WRITE: begin
            waddr_d = PTR_SZ'(inc(PTR_MAX'(waddr_q), DEPTH));
            state_d = winc ? HOLD : IDLE;
         end
         HOLD:    if (!winc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Full when the slot after the next write pointer is the read pointer.
   always_comb begin
      full_next    = (PTR_SZ'(inc(PTR_MAX'(waddr_d), DEPTH)) == raddr);
      full_at_zero = (PTR_SZ'(inc('0, DEPTH)) == raddr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         waddr_q    <= '0;
         write_en_q <= 1'b0;
         wfull_q    <= full_at_zero;
      end else begin
         state_q    <= state_d;
         waddr_q    <= waddr_d;
         write_en_q <= (state_d == WRITE);
         wfull_q    <= full_next;
      end
   end

   assign wfull    = wfull_q;
   assign write_en = write_en_q;
   assign waddr    = waddr_q;

`ifdef FIFO_WRITE_OVERFLOW_EN
   logic winc_q, woverflow_q;

   // Sticky flag for a new request arriving while full.
   always_ff @(posedge clk) begin
      if (rst) begin
         winc_q      <= 1'b0;
         woverflow_q <= 1'b0;
      end else begin
         winc_q <= winc;
         if (state_q == IDLE && winc && !winc_q && wfull_q) woverflow_q <= 1'b1;
      end
   end

   assign woverflow = woverflow_q;
`endif

endmodule

// File: tb/tb_fifo_write_logic.sv
// Self-checking bench for fifo_write_logic (DEPTH=3, PTR_SZ=2): vector table, corner sequence, random vs model.
module tb_fifo_write_logic;

   localparam int unsigned DEPTH  = 3;
   localparam int unsigned PTR_SZ = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              winc = 1'b0;
   logic [PTR_SZ-1:0] rq2_raddr = '0;
   logic              wfull, write_en;
   logic [PTR_SZ-1:0] waddr, waddr_gray;
   logic              ovf_out;

   int checks = 0;
   int errors = 0;

   // Reference model: episode-level view of the write side.
   int   m_waddr, m_raddr;
   logic m_we, m_wfull, m_served, m_prev_winc, m_ovf;
   int   gray_lut [4] = '{0, 1, 3, 2};

   fifo_write_logic #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) dut (
      .clk        (clk),
      .rst        (rst),
      .winc       (winc),
      .rq2_raddr  (rq2_raddr),
      .wfull      (wfull),
      .write_en   (write_en),
      .waddr      (waddr),
      .waddr_gray (waddr_gray)
`ifdef FIFO_WRITE_OVERFLOW_EN
      ,
      .woverflow  (ovf_out)
`endif
   );

`ifndef FIFO_WRITE_OVERFLOW_EN
   assign ovf_out = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       winc;
      logic [1:0] rq;
      logic       wfull;
      logic       we;
      logic [1:0] waddr;
      logic [1:0] gray;
      logic       ovf;
   } vec_t;

   vec_t tbl [20];

   function automatic int g2b(input logic [1:0] g);
      logic [1:0] b;
      for (int i = 0; i < 2; i++) b[i] = ^(g >> i);
      return int'(b);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic w, input logic [1:0] q);
      int nw;
      m_raddr = g2b(q);
      if (r) begin
         m_waddr = 0; m_we = 1'b0; m_served = 1'b0; m_prev_winc = 1'b0; m_ovf = 1'b0;
         m_wfull = (((0 + 1) % DEPTH) == m_raddr);
      end else begin
         nw = m_we ? (m_waddr + 1) % DEPTH : m_waddr;
         if (w && !m_prev_winc && m_wfull && !m_we) m_ovf = 1'b1;
         if (m_we) begin
            m_served = w;
            m_we     = 1'b0;
         end else if (w && !m_served && !m_wfull) begin
            m_we     = 1'b1;
            m_served = 1'b1;
         end else if (!w) begin
            m_served = 1'b0;
         end
         m_waddr     = nw;
         m_wfull     = (((nw + 1) % DEPTH) == m_raddr);
         m_prev_winc = w;
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [1:0] q);
      @(negedge clk);
      rst = r; winc = w; rq2_raddr = q;
      @(posedge clk);
      model_update(r, w, q);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_wfull"}, 32'(wfull), 32'(m_wfull));
      chk({tag, "_we"},    32'(write_en), 32'(m_we));
      chk({tag, "_waddr"}, 32'(waddr), 32'(m_waddr));
      chk({tag, "_gray"},  32'(waddr_gray), 32'(gray_lut[m_waddr]));
`ifdef FIFO_WRITE_OVERFLOW_EN
      chk({tag, "_ovf"},   32'(ovf_out), 32'(m_ovf));
`endif
   endtask

   initial begin
      int we_cnt;
      logic [1:0] rq_r;

      //            rst   winc  rq    wfull we    waddr gray  ovf
      tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 2'd3, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd2, 2'd3, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd2, 2'd3, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].rst, tbl[i].winc, tbl[i].rq);
         chk($sformatf("tbl%0d_wfull", i), 32'(wfull), 32'(tbl[i].wfull));
         chk($sformatf("tbl%0d_we", i),    32'(write_en), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_waddr", i), 32'(waddr), 32'(tbl[i].waddr));
         chk($sformatf("tbl%0d_gray", i),  32'(waddr_gray), 32'(tbl[i].gray));
`ifdef FIFO_WRITE_OVERFLOW_EN
         chk($sformatf("tbl%0d_ovf", i),   32'(ovf_out), 32'(tbl[i].ovf));
`endif
      end

      // winc held high while full, then held across the release of full.
      step(1'b0, 1'b1, 2'd0); step(1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b1, 2'd0); step(1'b0, 1'b0, 2'd0);
      chk("fill_wfull", 32'(wfull), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 2'd0);
         chk("held_full_we", 32'(write_en), 32'd0);
         chk("held_full_waddr", 32'(waddr), 32'd2);
         chk_model("held_full");
      end
      step(1'b0, 1'b1, 2'd1);
      chk("release_wfull", 32'(wfull), 32'd0);
      we_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 2'd1);
         if (write_en === 1'b1) we_cnt++;
         chk_model("held_release");
      end
      chk("held_release_one_write", 32'(we_cnt), 32'd1);
      chk("held_release_waddr", 32'(waddr), 32'd0);
      step(1'b0, 1'b0, 2'd1);
      chk_model("release_end");

      // Randomized traffic against the model.
      rq_r = 2'd0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 5) == 0) rq_r = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), rq_r);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_logic.md
FIFO_WRITE_LOGIC -- requirements
Module: fifo_write_logic

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of FIFO slots; legal range 2 <= DEPTH <= 2**PTR_SZ.
REQ-002 SHALL have parameter PTR_SZ, default 2: pointer width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port winc, input, 1: write request; each low-to-high episode requests exactly one write.
REQ-006 SHALL have port rq2_raddr, input, PTR_SZ: read pointer in Gray code, already synchronized into the clk domain.
REQ-007 SHALL have port wfull, output, 1: FIFO full, registered.
REQ-008 SHALL have port write_en, output, 1: one-cycle memory write strobe, registered.
REQ-009 SHALL have port waddr, output, PTR_SZ: binary write address, registered.
REQ-010 SHALL have port waddr_gray, output, PTR_SZ: Gray code of waddr, equal to waddr ^ (waddr >> 1), combinational from the waddr register.

Function
REQ-011 SHALL derive internal raddr as the Gray-to-binary conversion of rq2_raddr (raddr[MSB] = rq2_raddr[MSB], then each lower bit = raddr[i+1] ^ rq2_raddr[i]).
REQ-012 SHALL define inc(x) = 0 if x == DEPTH-1, else x+1; waddr wraps modulo DEPTH.
REQ-013 SHALL implement FSM states IDLE, WRITE and HOLD.
REQ-014 IDLE SHALL go to WRITE when winc=1 and wfull=0, and otherwise stay in IDLE.
REQ-015 WRITE SHALL last exactly one cycle, then go to HOLD if winc=1, else to IDLE.
REQ-016 HOLD SHALL stay in HOLD while winc=1 and go to IDLE when winc=0.
REQ-017 write_en SHALL be 1 exactly in the cycles where the state is WRITE.
REQ-018 waddr SHALL update to inc(waddr) on the clock edge that leaves WRITE; the memory write during WRITE uses the old waddr.
REQ-019 Each clock, wfull SHALL register (inc(waddr_next) == raddr), where waddr_next is the value waddr takes at that edge.
REQ-020 One slot SHALL always be kept unused, giving a usable capacity of DEPTH-1.
REQ-021 A winc asserted while wfull=1 SHALL be dropped with no write_en and no waddr change; the FSM stays in IDLE.
REQ-022 A winc held high across the deassertion of wfull SHALL then be accepted, as one write only.
REQ-023 A change of rq2_raddr SHALL be reflected in wfull one clock later.
REQ-024 The FIFO SHALL never be reported empty; empty detection belongs to the read side.

Reset
REQ-025 While rst=1 at a clock edge, the FSM SHALL go to IDLE and set waddr=0, write_en=0, and wfull=(inc(0)==raddr).
REQ-026 Reset during WRITE or HOLD SHALL abort the operation; waddr is not incremented.

Configuration
REQ-027 With macro FIFO_WRITE_OVERFLOW_EN defined, the block SHALL add output port woverflow, 1 bit, registered: a sticky flag set the cycle after any winc rising edge that is dropped because wfull=1, and cleared only by rst.
REQ-028 Without FIFO_WRITE_OVERFLOW_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package fifo_pkg SHALL hold the FSM state enumeration (IDLE=0, WRITE=1, HOLD=2; 2 bits) and the inc/gray2bin/bin2gray functions.
REQ-030 The pointer conversion SHALL be one sub-module, fifo_gray_conv (bin2gray and gray2bin, parameterized by PTR_SZ), shared with the read logic.
REQ-031 The rest of the block SHALL be flat: FSM, waddr counter and full compare.

Verification (DEPTH=3, PTR_SZ=2)
REQ-032 Reset with rq2_raddr=0 -> waddr=0, waddr_gray=0, write_en=0, wfull=0.
REQ-033 Two single-cycle winc pulses -> two one-cycle write_en pulses at waddr 0 then 1; waddr=2, waddr_gray=3, wfull=1.
REQ-034 Full, then winc pulse -> no write_en, waddr stays 2, woverflow=1 if FIFO_WRITE_OVERFLOW_EN is defined.
REQ-035 Full, set rq2_raddr=1 -> wfull=0 one clock later; a winc pulse then writes at 2, waddr wraps to 0, wfull=1.
REQ-036 winc held high for 5 cycles with room -> exactly one write_en; waddr advances by 1.
REQ-037 rst asserted in the WRITE cycle -> state IDLE, waddr=0, write_en=0 on the next cycle.
